// File: rtl/div_if.sv
// Divider handshake bundle between microcode sequencer and div_unit.
// master: sequencer side (drives start/operands); slave: divider side.
interface div_if;
    logic        start;
    logic        is_8_bit;
    logic        is_signed;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        complete;
    logic        error;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        tmp_wr_en;
    logic [15:0] tmp_wr_val;

    modport master (
        output start, is_8_bit, is_signed, dividend, divisor,
        input  busy, complete, error, quotient, remainder,
        input  tmp_wr_en, tmp_wr_val
    );

    modport slave (
        input  start, is_8_bit, is_signed, dividend, divisor,
        output busy, complete, error, quotient, remainder,
        output tmp_wr_en, tmp_wr_val
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/IDIV), one quotient bit per clock.
// Ports: clk, reset (sync, active-high), bus (div_if.slave: start,
// is_8_bit, is_signed, dividend, divisor -> busy, complete, error,
// quotient, remainder, tmp_wr_en, tmp_wr_val).
// Build option: define DIV_SIGNED_EN to compile in the signed path.
module div_unit (
    input  logic  clk,
    input  logic  reset,
    div_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WORKING = 2'd1,
        FIXUP   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        byte_q, byte_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] dvs_q, dvs_d;
    logic [16:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic        busy_q, busy_d;
    logic        complete_q, complete_d;
    logic        error_q, error_d;
    logic [15:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;
    logic        tmp_wr_en_q, tmp_wr_en_d;
`ifdef DIV_SIGNED_EN
    logic        sgn_q, sgn_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
`endif

    logic        sgn_in;
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_mag;
    logic [15:0] dvs_mag;
    logic [15:0] hi_mag;
    logic [15:0] lo_mag;
    logic [16:0] shifted;
    logic [16:0] diff;
    logic [15:0] q_fix;
    logic [15:0] r_fix;
    logic        ovf;

    // Operand magnitudes and signs at start time.
    always_comb begin
`ifdef DIV_SIGNED_EN
        sgn_in = bus.is_signed;
`else
        sgn_in = 1'b0;
`endif
        dvd_neg = sgn_in & (bus.is_8_bit ? bus.dividend[15]
                                         : bus.dividend[31]);
        dvs_neg = sgn_in & (bus.is_8_bit ? bus.divisor[7]
                                         : bus.divisor[15]);
        if (bus.is_8_bit) begin
            dvd_mag = {16'h0000, dvd_neg ? (~bus.dividend[15:0] + 16'd1)
                                         : bus.dividend[15:0]};
            dvs_mag = {8'h00, dvs_neg ? (~bus.divisor[7:0] + 8'd1)
                                      : bus.divisor[7:0]};
            hi_mag  = {8'h00, dvd_mag[15:8]};
            lo_mag  = {8'h00, dvd_mag[7:0]};
        end else begin
            dvd_mag = dvd_neg ? (~bus.dividend + 32'd1) : bus.dividend;
            dvs_mag = dvs_neg ? (~bus.divisor + 16'd1) : bus.divisor;
            hi_mag  = dvd_mag[31:16];
            lo_mag  = dvd_mag[15:0];
        end
    end

    // Restoring step: shift next dividend bit in, trial-subtract.
    // The partial remainder stays below the divisor, so bit 16 of the
    // difference is set exactly when the subtraction goes negative.
    always_comb begin
        shifted = {rem_q[15:0], byte_q ? lo_q[7] : lo_q[15]};
        diff    = shifted - {1'b0, dvs_q};
    end

    // Sign correction and overflow for the FIXUP cycle.
    always_comb begin
        q_fix = quo_q;
        r_fix = rem_q[15:0];
        ovf   = 1'b0;
`ifdef DIV_SIGNED_EN
        if (sgn_q) begin
            ovf = byte_q ? (quo_q > 16'h007F) : (quo_q > 16'h7FFF);
            if (qneg_q) q_fix = ~quo_q + 16'd1;
            if (rneg_q) r_fix = ~rem_q[15:0] + 16'd1;
            if (byte_q) begin
                q_fix = {8'h00, q_fix[7:0]};
                r_fix = {8'h00, r_fix[7:0]};
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        lo_d        = lo_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        busy_d      = busy_q;
        complete_d  = 1'b0;
        error_d     = error_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        tmp_wr_en_d = 1'b0;
`ifdef DIV_SIGNED_EN
        sgn_d  = sgn_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    byte_d  = bus.is_8_bit;
                    lo_d    = lo_mag;
                    dvs_d   = dvs_mag;
                    rem_d   = {1'b0, hi_mag};
                    quo_d   = 16'h0000;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
`ifdef DIV_SIGNED_EN
                    sgn_d  = sgn_in;
                    qneg_d = dvd_neg ^ dvs_neg;
                    rneg_d = dvd_neg;
`endif
                    // Zero divisor or a quotient wider than N bits.
                    if (dvs_mag == 16'h0000 || hi_mag >= dvs_mag) begin
                        error_d    = 1'b1;
                        complete_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        cnt_d   = bus.is_8_bit ? 5'd8 : 5'd16;
                        state_d = WORKING;
                    end
                end
            end
            WORKING: begin
                lo_d  = {lo_q[14:0], 1'b0};
                quo_d = {quo_q[14:0], ~diff[16]};
                rem_d = diff[16] ? shifted : diff;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = FIXUP;
            end
            FIXUP: begin
                quotient_d  = q_fix;
                remainder_d = r_fix;
                error_d     = ovf;
                tmp_wr_en_d = ~ovf;
                complete_d  = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            byte_q      <= 1'b0;
            lo_q        <= 16'h0000;
            dvs_q       <= 16'h0000;
            rem_q       <= 17'h00000;
            quo_q       <= 16'h0000;
            busy_q      <= 1'b0;
            complete_q  <= 1'b0;
            error_q     <= 1'b0;
            quotient_q  <= 16'h0000;
            remainder_q <= 16'h0000;
            tmp_wr_en_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q  <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            lo_q        <= lo_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            busy_q      <= busy_d;
            complete_q  <= complete_d;
            error_q     <= error_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            tmp_wr_en_q <= tmp_wr_en_d;
`ifdef DIV_SIGNED_EN
            sgn_q  <= sgn_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.complete   = complete_q;
    assign bus.error      = error_q;
    assign bus.quotient   = quotient_q;
    assign bus.remainder  = remainder_q;
    assign bus.tmp_wr_en  = tmp_wr_en_q;
    assign bus.tmp_wr_val = quotient_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Covers unsigned word/byte, errors, signed build, busy and reset cases.
module tb_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   errs   = 0;
    int   checks = 0;
    int   cyc;
    logic busy1;

    always #5 clk = ~clk;

    div_if bus ();

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one start in the current cycle (cycle 0) and waits for
    // complete; returns the cycle number it appeared in (40 = timeout).
    // Operands are scrambled after cycle 0 to prove they were captured.
    // alt_cyc: cycle in which a second (to be ignored) start is driven.
    task automatic run(input logic is8, input logic sgn,
                       input logic [31:0] dvd, input logic [15:0] dvs,
                       input int alt_cyc, output int c, output logic b1);
        bus.is_8_bit  = is8;
        bus.is_signed = sgn;
        bus.dividend  = dvd;
        bus.divisor   = dvs;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = 32'h0000_0001;
        bus.divisor  = 16'h0001;
        c  = 1;
        b1 = bus.busy;
        while (!bus.complete && c < 40) begin
            bus.start = (c == alt_cyc);
            @(posedge clk); #1;
            c++;
        end
        bus.start = 1'b0;
    endtask

    task automatic after_done(input string tag);
        @(posedge clk); #1;
        chk({tag, "_cpl_drop"}, bus.complete, 1'b0);
        chk({tag, "_busy_drop"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.is_8_bit  = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'h0;
        bus.divisor   = 16'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_cpl", bus.complete, 1'b0);
        chk("rst_err", bus.error, 1'b0);
        chk("rst_wen", bus.tmp_wr_en, 1'b0);
        chk("rst_quo", bus.quotient, 16'h0000);
        chk("rst_rem", bus.remainder, 16'h0000);
        chk("rst_wval", bus.tmp_wr_val, 16'h0000);

        // Unsigned word
        run(1'b0, 1'b0, 32'h0001_0000, 16'h0003, -1, cyc, busy1);
        chk("w_cyc", cyc, 18);
        chk("w_busy1", busy1, 1'b1);
        chk("w_err", bus.error, 1'b0);
        chk("w_quo", bus.quotient, 16'h5555);
        chk("w_rem", bus.remainder, 16'h0001);
        chk("w_wen", bus.tmp_wr_en, 1'b1);
        chk("w_wval", bus.tmp_wr_val, 16'h5555);
        after_done("w");
        chk("w_wen_drop", bus.tmp_wr_en, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("w_hold_quo", bus.quotient, 16'h5555);

        // Unsigned byte
        run(1'b1, 1'b0, 32'h0000_0064, 16'h0007, -1, cyc, busy1);
        chk("b_cyc", cyc, 10);
        chk("b_err", bus.error, 1'b0);
        chk("b_quo", bus.quotient, 16'h000E);
        chk("b_rem", bus.remainder, 16'h0002);
        after_done("b");

        // Word boundary: largest quotient without overflow
        run(1'b0, 1'b0, 32'hFFFE_FFFF, 16'hFFFF, -1, cyc, busy1);
        chk("wmax_cyc", cyc, 18);
        chk("wmax_quo", bus.quotient, 16'hFFFF);
        chk("wmax_rem", bus.remainder, 16'hFFFE);
        after_done("wmax");

        // Byte boundary: upper byte just below divisor
        run(1'b1, 1'b0, 32'h0000_0100, 16'h0002, -1, cyc, busy1);
        chk("bmax_cyc", cyc, 10);
        chk("bmax_quo", bus.quotient, 16'h0080);
        chk("bmax_rem", bus.remainder, 16'h0000);
        after_done("bmax");

        // Divide by zero
        run(1'b0, 1'b0, 32'h0000_1234, 16'h0000, -1, cyc, busy1);
        chk("dz_cyc", cyc, 1);
        chk("dz_err", bus.error, 1'b1);
        chk("dz_wen", bus.tmp_wr_en, 1'b0);
        after_done("dz");
        chk("dz_err_hold", bus.error, 1'b1);

        // Quotient overflow (upper half == divisor)
        run(1'b0, 1'b0, 32'h0003_0000, 16'h0003, -1, cyc, busy1);
        chk("ov_cyc", cyc, 1);
        chk("ov_err", bus.error, 1'b1);
        chk("ov_wen", bus.tmp_wr_en, 1'b0);
        after_done("ov");

`ifdef DIV_SIGNED_EN
        run(1'b0, 1'b1, 32'hFFFF_FFF9, 16'h0002, -1, cyc, busy1);
        chk("s_cyc", cyc, 18);
        chk("s_err", bus.error, 1'b0);
        chk("s_quo", bus.quotient, 16'hFFFD);
        chk("s_rem", bus.remainder, 16'hFFFF);
        chk("s_wval", bus.tmp_wr_val, 16'hFFFD);
        after_done("s");

        run(1'b0, 1'b1, 32'h0000_8000, 16'h0001, -1, cyc, busy1);
        chk("sov_cyc", cyc, 18);
        chk("sov_err", bus.error, 1'b1);
        chk("sov_wen", bus.tmp_wr_en, 1'b0);
        after_done("sov");
`else
        // is_signed ignored: treated as unsigned, upper half overflows
        run(1'b0, 1'b1, 32'hFFFF_FFF9, 16'h0002, -1, cyc, busy1);
        chk("us_cyc", cyc, 1);
        chk("us_err", bus.error, 1'b1);
        chk("us_wen", bus.tmp_wr_en, 1'b0);
        after_done("us");
`endif

        // Second start at cycle 5 must be ignored
        run(1'b0, 1'b0, 32'h0001_0000, 16'h0003, 5, cyc, busy1);
        chk("bz_cyc", cyc, 18);
        chk("bz_quo", bus.quotient, 16'h5555);
        chk("bz_rem", bus.remainder, 16'h0001);
        after_done("bz");

        // Reset in cycle 7 of a word divide
        bus.is_8_bit  = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'h0001_0000;
        bus.divisor   = 16'h0003;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 7) begin
            @(posedge clk); #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("ra_busy", bus.busy, 1'b0);
        chk("ra_cpl", bus.complete, 1'b0);
        chk("ra_err", bus.error, 1'b0);
        chk("ra_wen", bus.tmp_wr_en, 1'b0);
        chk("ra_quo", bus.quotient, 16'h0000);
        chk("ra_rem", bus.remainder, 16'h0000);
        chk("ra_wval", bus.tmp_wr_val, 16'h0000);

        // New start right after reset; an early complete would expose
        // a leftover from the aborted operation.
        run(1'b1, 1'b0, 32'h0000_0064, 16'h0007, -1, cyc, busy1);
        chk("rn_cyc", cyc, 10);
        chk("rn_quo", bus.quotient, 16'h000E);
        chk("rn_rem", bus.remainder, 16'h0002);
        after_done("rn");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
